// File: rtl/pong_pkg.sv
// pong_pkg: shared enums for the bounce-game core
package pong_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, POINT, OVER} state_e;
  typedef enum logic [1:0] {LEFT, STRAIGHT, RIGHT} angle_e;
  typedef enum logic {P1, P2} player_e;
endpackage

// File: rtl/push_edge.sv
// push_edge: samples the button bus on the bar tick and flags 0->1 transitions
module push_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic [3:0] push_i,
  output logic [3:0] press_o
);
  logic [3:0] new_q, old_q;
  // two-deep sample history per button, advanced only on the bar tick
  always_ff @(posedge clk)
    if (rst) begin
      new_q <= '0;
      old_q <= '0;
    end else if (tick_i) begin
      new_q <= push_i;
      old_q <= new_q;
    end
  assign press_o = tick_i ? new_q & ~old_q : '0;
endmodule

// File: rtl/pong_engine.sv
// pong_engine: two-bar bounce-game core with serve/point/game-over sequencing and scoring
module pong_engine
  import pong_pkg::*;
#(
  parameter int FIELD_W   = 8,
  parameter int FIELD_H   = 16,
  parameter int BAR1_Y    = 12,
  parameter int BAR2_Y    = 3,
  parameter int BAR_LEN   = 3,
  parameter int BAR_DIV   = 2000,
  parameter int BALL_DIV  = 4000000,
  parameter int HOLD_T    = 8,
  parameter int WIN_SCORE = 9,
  localparam int X_W      = $clog2(FIELD_W),
  localparam int Y_W      = $clog2(FIELD_H),
  localparam int SCORE_W  = $clog2(WIN_SCORE + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [3:0]         PUSH,
  output logic [X_W-1:0]     bar1_x,
  output logic [X_W-1:0]     bar2_x,
  output logic [X_W-1:0]     ball_x,
  output logic [Y_W-1:0]     ball_y,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [7:0]         rally
);
  localparam int BW = $clog2(BAR_DIV + 1);
  localparam int LW = $clog2(BALL_DIV + 1);
  localparam int HW = $clog2(HOLD_T + 1);
  localparam logic [X_W-1:0] BAR_MAX = X_W'(FIELD_W - BAR_LEN);
  localparam logic [X_W-1:0] X_MAX = X_W'(FIELD_W - 1);
  localparam logic [X_W-1:0] HALF = X_W'(BAR_LEN / 2);
  localparam logic [X_W:0] LEN = (X_W + 1)'(BAR_LEN);
  localparam logic [Y_W-1:0] ADJ1 = Y_W'(BAR1_Y - 1);
  localparam logic [Y_W-1:0] ADJ2 = Y_W'(BAR2_Y + 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  state_e state_q, state_d;
  player_e server_q, server_d;
  angle_e angle_q, angle_d, step_angle, hit_angle;
  logic up_q, up_d;
  logic [X_W-1:0] bar1_q, bar1_d, bar2_q, bar2_d, ball_x_q, ball_x_d;
  logic [X_W-1:0] def_bar, off, step_x, park_x;
  logic [Y_W-1:0] ball_y_q, ball_y_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic [7:0] rally_q, rally_d;
  logic [BW-1:0] bar_cnt_q;
  logic [LW-1:0] ball_cnt_q;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0] press;
  logic bar_tick, ball_tick, serve, at_adj, hit, miss, win, hold_done;
  push_edge u_push (
    .clk(CLK),
    .rst(RST),
    .tick_i(bar_tick),
    .push_i(PUSH),
    .press_o(press)
  );
  assign bar_tick = bar_cnt_q == BW'(BAR_DIV - 1);
  assign ball_tick = ball_cnt_q == LW'(BALL_DIV - 1);
  assign serve = state_q == IDLE && (server_q == P1 ? press[1] : press[3]);
  assign def_bar = up_q ? bar2_q : bar1_q;
  assign off = ball_x_q - def_bar;
  assign at_adj = ball_y_q == (up_q ? ADJ2 : ADJ1);
  assign hit = state_q == PLAY && ball_tick && at_adj && ball_x_q >= def_bar && {1'b0, off} < LEN;
  assign miss = state_q == PLAY && ball_tick && at_adj && !hit;
  assign win = up_q ? score1_q + 1'b1 == WIN : score2_q + 1'b1 == WIN;
  assign hold_done = ball_tick && hold_q == HW'(HOLD_T - 1);
  assign step_angle = angle_q == LEFT && ball_x_q == '0 ? RIGHT : angle_q == RIGHT && ball_x_q == X_MAX ? LEFT : angle_q;
  assign step_x = step_angle == LEFT ? ball_x_q - 1'b1 : step_angle == RIGHT ? ball_x_q + 1'b1 : ball_x_q;
  assign hit_angle = off == '0 ? LEFT : {1'b0, off} == LEN - 1'b1 ? RIGHT : STRAIGHT;
  assign park_x = (server_q == P1 ? bar1_d : bar2_d) + HALF;
  // bars: one cell per press, left beats right, clamped to the field; the serving press never moves its bar
  always_comb begin
    bar1_d = bar1_q;
    bar2_d = bar2_q;
    if (state_q != OVER && !(serve && server_q == P1))
      bar1_d = press[1] ? (bar1_q == '0 ? bar1_q : bar1_q - 1'b1) : press[0] && bar1_q != BAR_MAX ? bar1_q + 1'b1 : bar1_q;
    if (state_q != OVER && !(serve && server_q == P2))
      bar2_d = press[3] ? (bar2_q == '0 ? bar2_q : bar2_q - 1'b1) : press[2] && bar2_q != BAR_MAX ? bar2_q + 1'b1 : bar2_q;
  end
  // state register
  always_ff @(posedge CLK)
    if (RST) state_q <= IDLE;
    else state_q <= state_d;
  // next state: serve starts play, a miss ends the rally, the hold expires back to serving
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = serve ? PLAY : IDLE;
      PLAY:    state_d = miss ? (win ? OVER : POINT) : PLAY;
      POINT:   state_d = hold_done ? IDLE : POINT;
      default: state_d = OVER;
    endcase
  end
  // ball, scores and rally: park on the server while serving, step or bounce while playing
  always_comb begin
    server_d = server_q;
    angle_d = angle_q;
    up_d = up_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    score1_d = score1_q;
    score2_d = score2_q;
    rally_d = serve ? '0 : rally_q;
    hold_d = state_q == POINT ? (ball_tick ? hold_q + 1'b1 : hold_q) : '0;
    if (state_q == IDLE || (state_q == POINT && hold_done)) begin
      ball_x_d = park_x;
      ball_y_d = server_q == P1 ? ADJ1 : ADJ2;
      up_d = server_q == P1;
      angle_d = STRAIGHT;
    end
    if (hit) begin
      up_d = !up_q;
      angle_d = hit_angle;
      rally_d = rally_q == 8'hFF ? rally_q : rally_q + 1'b1;
    end else if (state_q == PLAY && ball_tick) begin
      ball_x_d = step_x;
      ball_y_d = up_q ? ball_y_q - 1'b1 : ball_y_q + 1'b1;
      angle_d = step_angle;
    end
    if (miss) begin
      score1_d = up_q ? score1_q + 1'b1 : score1_q;
      score2_d = up_q ? score2_q : score2_q + 1'b1;
      server_d = up_q ? P2 : P1;
    end
  end
  // datapath registers and the two tick prescalers
  always_ff @(posedge CLK)
    if (RST) begin
      server_q <= P1;
      angle_q <= STRAIGHT;
      up_q <= 1'b1;
      bar1_q <= '0;
      bar2_q <= BAR_MAX;
      ball_x_q <= HALF;
      ball_y_q <= ADJ1;
      score1_q <= '0;
      score2_q <= '0;
      rally_q <= '0;
      hold_q <= '0;
      bar_cnt_q <= '0;
      ball_cnt_q <= '0;
    end else begin
      server_q <= server_d;
      angle_q <= angle_d;
      up_q <= up_d;
      bar1_q <= bar1_d;
      bar2_q <= bar2_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      rally_q <= rally_d;
      hold_q <= hold_d;
      bar_cnt_q <= bar_tick ? '0 : bar_cnt_q + 1'b1;
      ball_cnt_q <= serve || ball_tick ? '0 : ball_cnt_q + 1'b1;
    end
  assign state = state_q;
  assign bar1_x = bar1_q;
  assign bar2_x = bar2_q;
  assign ball_x = ball_x_q;
  assign ball_y = ball_y_q;
  assign score1 = score1_q;
  assign score2 = score2_q;
  assign rally = rally_q;
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed game scenario plus random button play against a rule-level game model
module tb_pong_engine;
  import pong_pkg::*;
  localparam int W = 8, H = 16, B1Y = 12, B2Y = 3, L = 3, BD = 2, LD = 4, HT = 2, WS = 2;
  logic CLK = 0, RST = 1;
  logic [3:0] PUSH = '0;
  logic [2:0] bar1_x, bar2_x, ball_x;
  logic [3:0] ball_y;
  logic [1:0] state, score1, score2;
  logic [7:0] rally;
  int ncheck = 0, nfail = 0;
  state_e m_st;
  int m_b1, m_b2, m_x, m_y, m_dx, m_s1, m_s2, m_rally, m_srv, m_bc, m_lc, m_hold;
  bit m_up;
  logic [3:0] m_new, m_old;
  pong_engine #(.FIELD_W(W), .FIELD_H(H), .BAR1_Y(B1Y), .BAR2_Y(B2Y), .BAR_LEN(L),
    .BAR_DIV(BD), .BALL_DIV(LD), .HOLD_T(HT), .WIN_SCORE(WS)) dut (
    .CLK(CLK), .RST(RST), .PUSH(PUSH), .bar1_x(bar1_x), .bar2_x(bar2_x), .ball_x(ball_x),
    .ball_y(ball_y), .state(state), .score1(score1), .score2(score2), .rally(rally));
  always #5 CLK = ~CLK;
  function automatic int move(int b, bit l, bit r);
    return l ? (b > 0 ? b - 1 : b) : r ? (b < W - L ? b + 1 : b) : b;
  endfunction
  task automatic park();
    m_x = (m_srv == 1 ? m_b1 : m_b2) + L / 2;
    m_y = m_srv == 1 ? B1Y - 1 : B2Y + 1;
    m_up = m_srv == 1;
    m_dx = 0;
  endtask
  task automatic model_step(input logic [3:0] p, input bit r);
    bit bt, lt, srv_press;
    logic [3:0] pr;
    int ob1, ob2, brow, bx, nx;
    if (r) begin
      m_st = IDLE; m_srv = 1; m_b1 = 0; m_b2 = W - L; m_s1 = 0; m_s2 = 0; m_rally = 0;
      m_bc = 0; m_lc = 0; m_hold = 0; m_new = '0; m_old = '0;
      park();
      return;
    end
    bt = m_bc == BD - 1;
    lt = m_lc == LD - 1;
    pr = bt ? m_new & ~m_old : 4'b0;
    if (bt) begin m_old = m_new; m_new = p; end
    m_bc = bt ? 0 : m_bc + 1;
    m_lc = lt ? 0 : m_lc + 1;
    if (m_st == OVER) return;
    srv_press = m_st == IDLE && pr[m_srv == 1 ? 1 : 3];
    ob1 = m_b1;
    ob2 = m_b2;
    if (!(srv_press && m_srv == 1)) m_b1 = move(m_b1, pr[1], pr[0]);
    if (!(srv_press && m_srv == 2)) m_b2 = move(m_b2, pr[3], pr[2]);
    if (m_st == IDLE) begin
      park();
      if (srv_press) begin m_st = PLAY; m_rally = 0; m_lc = 0; end
    end else if (m_st == PLAY && lt) begin
      brow = m_up ? B2Y : B1Y;
      bx = m_up ? ob2 : ob1;
      if (m_y == brow + (m_up ? 1 : -1) && m_x >= bx && m_x < bx + L) begin
        m_dx = m_x == bx ? -1 : m_x == bx + L - 1 ? 1 : 0;
        m_up = !m_up;
        if (m_rally < 255) m_rally++;
      end else begin
        nx = m_x + m_dx;
        if (nx < 0 || nx > W - 1) begin m_dx = -m_dx; nx = m_x + m_dx; end
        m_x = nx;
        m_y += m_up ? -1 : 1;
        if (m_y == brow) begin
          if (m_up) begin m_s1++; m_srv = 2; end else begin m_s2++; m_srv = 1; end
          m_st = (m_s1 == WS || m_s2 == WS) ? OVER : POINT;
          m_hold = 0;
        end
      end
    end else if (m_st == POINT && lt) begin
      m_hold++;
      if (m_hold == HT) begin m_st = IDLE; park(); end
    end
  endtask
  task automatic cycle(input logic [3:0] p, input bit r);
    logic [26:0] got, exp;
    PUSH = p;
    RST = r;
    @(posedge CLK);
    model_step(p, r);
    #1;
    got = {state, bar1_x, bar2_x, ball_x, ball_y, score1, score2, rally};
    exp = {2'(m_st), 3'(m_b1), 3'(m_b2), 3'(m_x), 4'(m_y), 2'(m_s1), 2'(m_s2), 8'(m_rally)};
    ncheck++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL model t=%0t got=%h exp=%h (state,bar1,bar2,bx,by,s1,s2,rally)", $time, got, exp);
    end
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    ncheck++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic press(input logic [3:0] p);
    repeat (4) cycle(p, 0);
    repeat (4) cycle(4'b0, 0);
  endtask
  initial begin
    int n;
    logic [3:0] y0, p;
    repeat (2) cycle(4'b0, 1);
    press(4'b0010);
    repeat (10) cycle(4'b0, 0);
    chk("mid_play", state, PLAY);
    repeat (3) cycle(4'b0, 1);
    chk("rst_state", state, IDLE);
    chk("rst_bar1", bar1_x, 0);
    chk("rst_bar2", bar2_x, 5);
    chk("rst_ball_x", ball_x, 1);
    chk("rst_ball_y", ball_y, 11);
    chk("rst_scores", {score1, score2}, 0);
    chk("rst_rally", rally, 0);
    press(4'b1000);
    press(4'b1000);
    chk("bar2_moved", bar2_x, 3);
    for (int i = 1; i <= 3; i++) begin
      press(4'b0001);
      chk("bar1_step", bar1_x, i);
      chk("ball_track", ball_x, i + 1);
    end
    press(4'b0010);
    chk("serve_state", state, PLAY);
    chk("serve_bar1", bar1_x, 3);
    n = 0;
    while (rally != 1 && n < 200) begin cycle(4'b0, 0); n++; end
    chk("to_hit", int'(n < 200), 1);
    chk("hit_x", ball_x, 4);
    chk("hit_y", ball_y, 4);
    press(4'b1010);
    press(4'b1000);
    press(4'b1000);
    chk("bar1_left", bar1_x, 2);
    chk("bar2_left", bar2_x, 0);
    n = 0;
    while (ball_x != 7 && n < 200) begin cycle(4'b0, 0); n++; end
    chk("to_wall", int'(n < 200), 1);
    y0 = ball_y;
    n = 0;
    while (ball_y == y0 && n < 20) begin cycle(4'b0, 0); n++; end
    chk("wall_x", ball_x, 6);
    chk("wall_state", state, PLAY);
    n = 0;
    while (state != POINT && n < 200) begin cycle(4'b0, 0); n++; end
    chk("to_point", int'(n < 200), 1);
    chk("pt_score1", score1, 1);
    chk("pt_score2", score2, 0);
    chk("pt_ball_x", ball_x, 2);
    chk("pt_ball_y", ball_y, 3);
    n = 0;
    while (state != IDLE && n < 100) begin cycle(4'b0, 0); n++; end
    chk("to_idle", int'(n < 100), 1);
    chk("park_x", ball_x, 1);
    chk("park_y", ball_y, 4);
    press(4'b1000);
    chk("p2_serve", state, PLAY);
    chk("p2_serve_bar", bar2_x, 0);
    press(4'b0110);
    press(4'b0110);
    n = 0;
    while (state != OVER && n < 200) begin cycle(4'b0, 0); n++; end
    chk("to_over", int'(n < 200), 1);
    chk("over_score1", score1, 2);
    chk("over_score2", score2, 0);
    press(4'b1111);
    press(4'b1111);
    chk("over_bar1", bar1_x, 0);
    chk("over_bar2", bar2_x, 2);
    chk("over_ball_x", ball_x, 1);
    chk("over_ball_y", ball_y, 3);
    chk("over_state", state, OVER);
    repeat (3) cycle(4'b0, 1);
    chk("over_rst", state, IDLE);
    chk("over_rst_sc", {score1, score2}, 0);
    p = '0;
    repeat (4000) begin
      if ($urandom_range(0, 7) == 0) p = 4'($urandom_range(0, 15));
      cycle(p, $urandom_range(0, 499) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", ncheck, nfail);
    $finish;
  end
endmodule
